// File: rtl/dvbc_qam_demapper.sv
// DVB-C receive demapper: hard-slices 16/64/256-QAM I/Q, differentially decodes the
// quadrant MSBs and packs m-bit symbol words MSB-first into bytes.
module dvbc_qam_demapper #(
    parameter int unsigned IQ_W   = 12,
    parameter int unsigned LOG2_A = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [1:0]      mode_i,
    input  logic            clear_i,
    input  logic            sym_valid_i,
    output logic            sym_ready_o,
    input  logic [IQ_W-1:0] sym_i_i,
    input  logic [IQ_W-1:0] sym_q_i,
    output logic            byte_valid_o,
    input  logic            byte_ready_i,
    output logic [7:0]      byte_o
);

    localparam int unsigned XW    = IQ_W + 1;
    localparam int unsigned ACC_W = 15;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SYM_W = 8;

    localparam logic [1:0] MODE_16  = 2'b00;
    localparam logic [1:0] MODE_64  = 2'b01;
    localparam logic [1:0] MODE_RSV = 2'b11;

    logic             en_r;
    logic [1:0]       mode_r;
    logic             ip_r, qp_r;
    logic             slice_full_r;
    logic [SYM_W-1:0] slice_r;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             byte_valid_r;

    logic             en_nxt;
    logic [1:0]       mode_nxt;
    logic             ip_nxt, qp_nxt;
    logic             slice_full_nxt;
    logic [SYM_W-1:0] slice_nxt;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             byte_valid_nxt;

    logic [1:0]            mode_eff;
    logic                  ik, qk, pi, pq, dec_a, dec_b;
    logic signed [XW-1:0]  i_ext, q_ext, fx, fy;
    logic [2:0]            lmax, lx, ly, gx, gy;
    logic [SYM_W-1:0]      sym_word;

    logic [CNT_W-1:0] m_bits;
    logic             byte_fire, slice_move, sym_fire;
    logic [ACC_W-1:0] acc_base, ins;
    logic [CNT_W-1:0] cnt_base;

    // Level index along one folded axis, saturated to the outermost ring.
    function automatic logic [2:0] slice_lvl(input logic signed [XW-1:0] v,
                                             input logic [2:0] lim);
        logic [XW-1:0] s;
        s = $unsigned(v) >> (LOG2_A + 1);
        if (s > XW'(lim)) slice_lvl = lim;
        else              slice_lvl = s[2:0];
    endfunction

    // Stage 1: fold to first quadrant, slice, Gray-code, differential decode.
    always_comb begin
        mode_eff = mode_r;
        if (clear_i && (mode_i != MODE_RSV))
            mode_eff = mode_i;
        pi    = clear_i ? 1'b0 : ip_r;
        pq    = clear_i ? 1'b0 : qp_r;
        ik    = sym_i_i[IQ_W-1];
        qk    = sym_q_i[IQ_W-1];
        i_ext = {sym_i_i[IQ_W-1], sym_i_i};
        q_ext = {sym_q_i[IQ_W-1], sym_q_i};
        fx    = i_ext;
        fy    = q_ext;
        case ({ik, qk})
            2'b10:   begin fx = q_ext;  fy = -i_ext; end
            2'b11:   begin fx = -i_ext; fy = -q_ext; end
            2'b01:   begin fx = -q_ext; fy = i_ext;  end
            default: begin fx = i_ext;  fy = q_ext;  end
        endcase
        case (mode_eff)
            MODE_16: lmax = 3'd1;
            MODE_64: lmax = 3'd3;
            default: lmax = 3'd7;
        endcase
        lx = slice_lvl(fx, lmax);
        ly = slice_lvl(fy, lmax);
        gx = lx ^ (lx >> 1);
        gy = ly ^ (ly >> 1);
        if ((ik ^ qk ^ pi ^ pq) == 1'b0) begin
            dec_a = ik ^ pi;
            dec_b = qk ^ pq;
        end else begin
            dec_a = ik ^ pq;
            dec_b = qk ^ pi;
        end
        case (mode_eff)
            MODE_16: sym_word = {4'b0000, dec_a, dec_b, gy[0], gx[0]};
            MODE_64: sym_word = {2'b00, dec_a, dec_b, gy[1:0], gx[1:0]};
            default: sym_word = {dec_a, dec_b, gy, gx};
        endcase
    end

    // Stage 2 handshakes and byte packer datapath.
    always_comb begin
        case (mode_r)
            MODE_16: m_bits = CNT_W'(4);
            MODE_64: m_bits = CNT_W'(6);
            default: m_bits = CNT_W'(8);
        endcase
        byte_fire   = byte_valid_r & byte_ready_i;
        slice_move  = slice_full_r & (~byte_valid_r | byte_fire);
        sym_ready_o = en_r & (~slice_full_r | slice_move);
        sym_fire    = sym_valid_i & sym_ready_o;
        acc_base    = byte_fire ? (acc_r << 8) : acc_r;
        cnt_base    = byte_fire ? (cnt_r - CNT_W'(8)) : cnt_r;
        ins         = (ACC_W'(slice_r) << (CNT_W'(ACC_W) - m_bits)) >> cnt_base;
    end

    // Next state; clear_i dominates and restarts the stream.
    always_comb begin
        en_nxt         = 1'b1;
        mode_nxt       = mode_r;
        ip_nxt         = ip_r;
        qp_nxt         = qp_r;
        slice_full_nxt = slice_full_r;
        slice_nxt      = slice_r;
        acc_nxt        = acc_r;
        cnt_nxt        = cnt_r;
        byte_valid_nxt = byte_valid_r;
        if (clear_i) begin
            mode_nxt       = mode_eff;
            acc_nxt        = '0;
            cnt_nxt        = '0;
            byte_valid_nxt = 1'b0;
            slice_full_nxt = sym_fire;
            ip_nxt         = sym_fire & ik;
            qp_nxt         = sym_fire & qk;
            if (sym_fire)
                slice_nxt = sym_word;
        end else begin
            acc_nxt        = acc_base | (slice_move ? ins : ACC_W'(0));
            cnt_nxt        = cnt_base + (slice_move ? m_bits : CNT_W'(0));
            byte_valid_nxt = (cnt_nxt >= CNT_W'(8));
            if (sym_fire) begin
                slice_nxt      = sym_word;
                slice_full_nxt = 1'b1;
                ip_nxt         = ik;
                qp_nxt         = qk;
            end else if (slice_move) begin
                slice_full_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_r         <= 1'b0;
            mode_r       <= MODE_16;
            ip_r         <= 1'b0;
            qp_r         <= 1'b0;
            slice_full_r <= 1'b0;
            slice_r      <= '0;
            acc_r        <= '0;
            cnt_r        <= '0;
            byte_valid_r <= 1'b0;
        end else begin
            en_r         <= en_nxt;
            mode_r       <= mode_nxt;
            ip_r         <= ip_nxt;
            qp_r         <= qp_nxt;
            slice_full_r <= slice_full_nxt;
            slice_r      <= slice_nxt;
            acc_r        <= acc_nxt;
            cnt_r        <= cnt_nxt;
            byte_valid_r <= byte_valid_nxt;
        end
    end

    assign byte_valid_o = byte_valid_r;
    assign byte_o       = acc_r[ACC_W-1 -: 8];

endmodule

// File: tb/tb_dvbc_qam_demapper.sv
// Directed bench for dvbc_qam_demapper: hand-decoded symbols checked against emitted bytes.
module tb_dvbc_qam_demapper;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [1:0]  mode_i = 2'b00;
    logic        clear_i = 1'b0;
    logic        sym_valid_i = 1'b0;
    logic        sym_ready_o;
    logic [11:0] sym_i_i = '0;
    logic [11:0] sym_q_i = '0;
    logic        byte_valid_o;
    logic        byte_ready_i = 1'b0;
    logic [7:0]  byte_o;

    int vectors = 0;
    int errors = 0;
    int stalls = 0;
    int send_timeouts = 0;
    logic [7:0] got_q[$];

    always #5 clk_i = ~clk_i;

    dvbc_qam_demapper #(.IQ_W(12), .LOG2_A(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .mode_i(mode_i), .clear_i(clear_i),
        .sym_valid_i(sym_valid_i), .sym_ready_o(sym_ready_o),
        .sym_i_i(sym_i_i), .sym_q_i(sym_q_i),
        .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i), .byte_o(byte_o)
    );

    // Byte monitor: a byte is taken at the next rising edge when valid & ready.
    always @(negedge clk_i) begin
        #2;
        if (rst_n_i && byte_valid_o && byte_ready_i)
            got_q.push_back(byte_o);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_clear(input logic [1:0] m);
        clear_i = 1'b1;
        mode_i  = m;
        @(negedge clk_i);
        clear_i = 1'b0;
    endtask

    task automatic send_sym(input logic signed [11:0] si, input logic signed [11:0] sq);
        int t;
        t = 0;
        sym_valid_i = 1'b1;
        sym_i_i     = si;
        sym_q_i     = sq;
        #1;
        while (!sym_ready_o && t < 100) begin
            @(negedge clk_i);
            #1;
            t++;
            stalls++;
        end
        if (!sym_ready_o) send_timeouts++;
        @(negedge clk_i);
        sym_valid_i = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int t;
        t = 0;
        while (got_q.size() < n && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        #1;
        vectors++; if (sym_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", sym_ready_o); end
        vectors++; if (byte_valid_o !== 1'b0) begin errors++; $display("FAIL rst_bvalid got=%b exp=0", byte_valid_o); end
        vectors++; if (byte_o !== 8'h00) begin errors++; $display("FAIL rst_byte got=%h exp=00", byte_o); end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        vectors++; if (sym_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready_early got=%b exp=0", sym_ready_o); end
        @(negedge clk_i);
        #1;
        vectors++; if (sym_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_rise got=%b exp=1", sym_ready_o); end
        @(negedge clk_i);
    endtask

    task automatic test_16qam();
        byte_ready_i = 1'b1;
        do_clear(2'b00);
        got_q.delete();
        send_sym(12'sd48, 12'sd16);
        send_sym(-12'sd16, -12'sd48);
        wait_bytes(1);
        vectors++; if (got_q.size() !== 1) begin errors++; $display("FAIL qam16_count got=%0d exp=1", got_q.size()); end
        vectors++; if (got_q[0] !== 8'h1E) begin errors++; $display("FAIL qam16_byte got=%h exp=1e", got_q[0]); end
    endtask

    task automatic test_256qam_latency();
        byte_ready_i = 1'b1;
        do_clear(2'b10);
        got_q.delete();
        send_sym(12'sd2047, 12'sd2047);
        #1;
        vectors++; if (byte_valid_o !== 1'b0) begin errors++; $display("FAIL lat_early got=%b exp=0", byte_valid_o); end
        @(negedge clk_i);
        #1;
        vectors++; if (byte_valid_o !== 1'b1) begin errors++; $display("FAIL lat_valid got=%b exp=1", byte_valid_o); end
        vectors++; if (byte_o !== 8'h24) begin errors++; $display("FAIL lat_byte got=%h exp=24", byte_o); end
        @(negedge clk_i);
        wait_bytes(1);
        vectors++; if (got_q.size() !== 1 || got_q[0] !== 8'h24) begin
            errors++; $display("FAIL qam256_sat count=%0d first=%h exp 1 x 24", got_q.size(), got_q[0]);
        end
    endtask

    task automatic test_64qam_mode_hold();
        logic [7:0] exp_b [3] = '{8'h03, 8'hF0, 8'h3F};
        byte_ready_i = 1'b1;
        do_clear(2'b01);
        do_clear(2'b11);
        got_q.delete();
        send_sym(12'sd16, 12'sd16);
        send_sym(-12'sd80, -12'sd80);
        send_sym(-12'sd16, -12'sd16);
        send_sym(12'sd80, 12'sd80);
        wait_bytes(3);
        vectors++; if (got_q.size() !== 3) begin errors++; $display("FAIL qam64_count got=%0d exp=3", got_q.size()); end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got_q[k] !== exp_b[k]) begin errors++; $display("FAIL qam64_byte%0d got=%h exp=%h", k, got_q[k], exp_b[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [5] = '{8'h80, 8'h99, 8'hA0, 8'h40, 8'h60};
        byte_ready_i = 1'b1;
        do_clear(2'b10);
        got_q.delete();
        stalls = 0;
        send_timeouts = 0;
        send_sym(-12'sd16, 12'sd16);
        send_sym(-12'sd48, -12'sd80);
        send_sym(12'sd240, -12'sd16);
        send_sym(-12'sd16, -12'sd16);
        send_sym(-12'sd2048, 12'sd0);
        wait_bytes(5);
        vectors++; if (stalls !== 0) begin errors++; $display("FAIL b2b_stalls got=%0d exp=0", stalls); end
        vectors++; if (got_q.size() !== 5) begin errors++; $display("FAIL b2b_count got=%0d exp=5", got_q.size()); end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (got_q[k] !== exp_b[k]) begin errors++; $display("FAIL b2b_byte%0d got=%h exp=%h", k, got_q[k], exp_b[k]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b [6] = '{8'h19, 8'h04, 8'h3A, 8'h35, 8'h20, 8'h16};
        logic [7:0] held;
        byte_ready_i = 1'b0;
        do_clear(2'b10);
        got_q.delete();
        send_timeouts = 0;
        fork
            begin
                send_sym(12'sd48, 12'sd80);
                send_sym(12'sd240, 12'sd16);
                send_sym(12'sd112, 12'sd176);
                send_sym(12'sd208, 12'sd144);
                send_sym(12'sd16, 12'sd240);
                send_sym(12'sd144, 12'sd112);
            end
            begin
                repeat (3) @(negedge clk_i);
                #1;
                held = byte_o;
                repeat (7) @(negedge clk_i);
                #1;
                vectors++; if (sym_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", sym_ready_o); end
                vectors++; if (byte_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", byte_valid_o); end
                vectors++; if (byte_o !== 8'h19) begin errors++; $display("FAIL bp_byte got=%h exp=19", byte_o); end
                vectors++; if (byte_o !== held) begin errors++; $display("FAIL bp_stable got=%h exp=%h", byte_o, held); end
                @(negedge clk_i);
                byte_ready_i = 1'b1;
            end
        join
        wait_bytes(6);
        vectors++; if (send_timeouts !== 0) begin errors++; $display("FAIL bp_timeout got=%0d exp=0", send_timeouts); end
        vectors++; if (got_q.size() !== 6) begin errors++; $display("FAIL bp_count got=%0d exp=6", got_q.size()); end
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (got_q[k] !== exp_b[k]) begin errors++; $display("FAIL bp_byte%0d got=%h exp=%h", k, got_q[k], exp_b[k]); end
        end
    endtask

    task automatic test_clear();
        byte_ready_i = 1'b1;
        do_clear(2'b00);
        got_q.delete();
        send_sym(-12'sd16, -12'sd48);
        repeat (2) @(negedge clk_i);
        #1;
        vectors++; if (byte_valid_o !== 1'b0) begin errors++; $display("FAIL clr_partial got=%b exp=0", byte_valid_o); end
        @(negedge clk_i);
        do_clear(2'b00);
        send_sym(12'sd48, 12'sd16);
        send_sym(-12'sd16, 12'sd48);
        wait_bytes(1);
        vectors++; if (got_q.size() !== 1) begin errors++; $display("FAIL clr_count got=%0d exp=1", got_q.size()); end
        vectors++; if (got_q[0] !== 8'h19) begin errors++; $display("FAIL clr_byte got=%h exp=19", got_q[0]); end
    endtask

    task automatic test_reset_mid();
        byte_ready_i = 1'b0;
        do_clear(2'b10);
        send_sym(12'sd2047, 12'sd2047);
        repeat (2) @(negedge clk_i);
        #1;
        vectors++; if (byte_valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre got=%b exp=1", byte_valid_o); end
        #2;
        rst_n_i = 1'b0;
        #1;
        vectors++; if (byte_valid_o !== 1'b0) begin errors++; $display("FAIL mid_bvalid got=%b exp=0", byte_valid_o); end
        vectors++; if (byte_o !== 8'h00) begin errors++; $display("FAIL mid_byte got=%h exp=00", byte_o); end
        vectors++; if (sym_ready_o !== 1'b0) begin errors++; $display("FAIL mid_ready got=%b exp=0", sym_ready_o); end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        byte_ready_i = 1'b1;
        do_clear(2'b11);
        got_q.delete();
        send_sym(12'sd48, 12'sd16);
        send_sym(-12'sd16, -12'sd48);
        wait_bytes(1);
        vectors++; if (got_q.size() !== 1) begin errors++; $display("FAIL mid_count got=%0d exp=1", got_q.size()); end
        vectors++; if (got_q[0] !== 8'h1E) begin errors++; $display("FAIL mid_mode got=%h exp=1e", got_q[0]); end
    endtask

    initial begin
        test_reset();
        test_16qam();
        test_256qam_latency();
        test_64qam_mode_hold();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
